// File: rtl/disp_share_arbiter.sv
// Round-robin time-slice arbiter sharing one 4-digit seven-segment display path
// between NREQ requesters, holding each winner for at least HOLD_CYC cycles.
module disp_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 50000000,
    parameter int CW       = 32
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   hexs_in,
    input  logic [4*NREQ-1:0]    les_in,
    input  logic [4*NREQ-1:0]    pts_in,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [15:0]          HEXS,
    output logic [3:0]           LES,
    output logic [3:0]           points
);

    localparam int              LW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0]   RELOAD    = CW'(HOLD_CYC - 1);
    localparam logic [LW-1:0]   LAST_INIT = LW'(NREQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [LW-1:0]   last_owner;
    logic [LW-1:0]   pick;
    logic [NREQ-1:0] owner_mask;
    logic            others;
    logic [15:0]     hexs_arr [NREQ];
    logic [3:0]      les_arr  [NREQ];
    logic [3:0]      pts_arr  [NREQ];

    function automatic logic [LW-1:0] wrap_idx(input logic [LW-1:0] base, input int off);
        return LW'((int'(base) + off) % NREQ);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            hexs_arr[i] = hexs_in[16*i +: 16];
            les_arr[i]  = les_in[4*i +: 4];
            pts_arr[i]  = pts_in[4*i +: 4];
        end
    end

    // Scan from farthest to nearest so the closest requester after last_owner wins;
    // last_owner itself is the final candidate, which only matters from IDLE.
    always_comb begin
        pick = last_owner;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[wrap_idx(last_owner, i)]) begin
                pick = wrap_idx(last_owner, i);
            end
        end
    end

    // While in OWN, last_owner is the current owner.
    assign owner_mask = NREQ'(1) << last_owner;
    assign others     = |(req & ~owner_mask);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            counter    <= '0;
            last_owner <= LAST_INIT;
            grant      <= '0;
            busy       <= 1'b0;
            HEXS       <= '0;
            LES        <= '0;
            points     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= OWN;
                        grant      <= NREQ'(1) << pick;
                        busy       <= 1'b1;
                        last_owner <= pick;
                        counter    <= RELOAD;
                        HEXS       <= hexs_arr[pick];
                        LES        <= les_arr[pick];
                        points     <= pts_arr[pick];
                    end
                end
                OWN: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                        if (req[last_owner]) begin
                            HEXS   <= hexs_arr[last_owner];
                            LES    <= les_arr[last_owner];
                            points <= pts_arr[last_owner];
                        end
                    end else if (others) begin
                        grant      <= NREQ'(1) << pick;
                        last_owner <= pick;
                        counter    <= RELOAD;
                        HEXS       <= hexs_arr[pick];
                        LES        <= les_arr[pick];
                        points     <= pts_arr[pick];
                    end else if (req[last_owner]) begin
                        counter <= RELOAD;
                        HEXS    <= hexs_arr[last_owner];
                        LES     <= les_arr[last_owner];
                        points  <= pts_arr[last_owner];
                    end else begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        HEXS   <= '0;
                        LES    <= '0;
                        points <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
